// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: two request/response ports.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [DATA_W-1:0] addr0;
  logic [DATA_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ready0;
  logic              ready1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              err0;
  logic              err1;

  // Requesters drive requests and consume grants/responses.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ready0, ready1, rvalid0, rvalid1, rdata0, rdata1, err0, err1
  );

  // The arbiter consumes requests and produces grants/responses.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ready0, ready1, rvalid0, rvalid1, rdata0, rdata1, err0, err1
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one single-port data memory
// between the CPU (port 0) and the debug/DMA loader (port 1).
module dmem_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     bus,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int unsigned       CNT_W      = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  BURST_MAX  = CNT_W'(MAX_BURST);
  localparam logic [DATA_W-1:0] ADDR_LIMIT = DATA_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  burst_cnt, burst_nxt;
  logic              last_owner, last_nxt;

  logic              gnt_vld;
  logic              gnt_port;
  logic              fresh;
  logic              own;
  logic              own_req;
  logic              oth_req;

  logic              sel_we;
  logic [DATA_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              addr_bad;

  logic              resp_valid;
  logic              resp_port;
  logic              resp_err;
  logic              rvalid0_w;
  logic              rvalid1_w;

  // Arbitration state, burst counter and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_nxt;
      last_owner <= last_nxt;
    end
  end

  // Grant selection and ownership transitions; a grant to a new owner
  // ("fresh") restarts the burst count with no idle bubble.
  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    last_nxt  = last_owner;
    gnt_vld   = 1'b0;
    gnt_port  = 1'b0;
    fresh     = 1'b0;
    own       = (state == OWN1);
    own_req   = own ? bus.req1 : bus.req0;
    oth_req   = own ? bus.req0 : bus.req1;
    case (state)
      IDLE: begin
        fresh = 1'b1;
        if (bus.req0 && bus.req1) begin
          gnt_vld  = 1'b1;
          gnt_port = ~last_owner;
        end else if (bus.req0 || bus.req1) begin
          gnt_vld  = 1'b1;
          gnt_port = bus.req1;
        end
      end
      OWN0, OWN1: begin
        if (own_req && !(oth_req && burst_cnt == BURST_MAX)) begin
          gnt_vld  = 1'b1;
          gnt_port = own;
          if (burst_cnt != BURST_MAX) burst_nxt = burst_cnt + CNT_W'(1);
        end else begin
          last_nxt = own;
          fresh    = 1'b1;
          if (oth_req) begin
            gnt_vld  = 1'b1;
            gnt_port = ~own;
          end else begin
            state_nxt = IDLE;
            burst_nxt = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) gnt_vld = 1'b0;
    if (gnt_vld && fresh) begin
      state_nxt = gnt_port ? OWN1 : OWN0;
      burst_nxt = CNT_W'(1);
    end
  end

  // Granted-port mux and memory strobes; out-of-range grants never reach the array.
  always_comb begin
    sel_we         = gnt_port ? bus.we1    : bus.we0;
    sel_addr       = gnt_port ? bus.addr1  : bus.addr0;
    sel_wdata      = gnt_port ? bus.wdata1 : bus.wdata0;
    addr_bad       = (sel_addr >= ADDR_LIMIT);
    mem_address    = '0;
    mem_write_data = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    if (gnt_vld && !addr_bad) begin
      mem_address    = sel_addr;
      mem_write_data = sel_wdata;
      mem_write      = sel_we;
      mem_read       = ~sel_we;
    end
  end

  // One-cycle response tracker for accepted reads and rejected accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_port  <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= gnt_vld && (addr_bad || !sel_we);
      resp_port  <= gnt_port;
      resp_err   <= gnt_vld && addr_bad;
    end
  end

  assign rvalid0_w   = resp_valid && !resp_port && !resp_err;
  assign rvalid1_w   = resp_valid &&  resp_port && !resp_err;

  assign bus.ready0  = gnt_vld && !gnt_port;
  assign bus.ready1  = gnt_vld &&  gnt_port;
  assign bus.rvalid0 = rvalid0_w;
  assign bus.rvalid1 = rvalid1_w;
  assign bus.err0    = resp_valid && !resp_port && resp_err;
  assign bus.err1    = resp_valid &&  resp_port && resp_err;
  assign bus.rdata0  = rvalid0_w ? mem_read_data : '0;
  assign bus.rdata1  = rvalid1_w ? mem_read_data : '0;

endmodule
